free_list: RTL and testbench
============================

FREE_LIST -- requirements
Module: free_list

Interface
REQ-001 SHALL have parameter PHYS_BITS, default 6, physical register index width.
REQ-002 SHALL have parameter ARCH_BITS, default 5, architectural register index width; DEPTH = 2**PHYS_BITS - 2**ARCH_BITS (default 32), a power of two.
REQ-003 SHALL have port clk  input  1  clock.
REQ-004 SHALL have port rst  input  1  reset: synchronous, active-high.
REQ-005 SHALL have port flush  input  1  pipeline flush / mispredict recovery.
REQ-006 SHALL have port enq_valid  input  1  commit frees a register; high only for a committed write with rd != x0.
REQ-007 SHALL have port enq_pd  input  PHYS_BITS  freed physical register, the old mapping replaced at commit.
REQ-008 SHALL have port deq_ready  input  1  rename requests a free register.
REQ-009 SHALL have port deq_valid  output  1  a free register is available.
REQ-010 SHALL have port deq_pd  output  PHYS_BITS  free register offered at head.
REQ-011 SHALL have port count  output  PHYS_BITS  free entries, 0..DEPTH.
REQ-012 SHALL have port overflow_err  output  1  sticky; enqueue attempted while full.

Function
REQ-013 SHALL be a circular queue of DEPTH entries, with head/tail pointers of log2(DEPTH)+1 bits; the MSB is the wrap bit.
REQ-014 SHALL dequeue on a cycle with deq_valid && deq_ready && !flush; head advances by 1; the entry is not cleared.
REQ-015 SHALL enqueue on a cycle with enq_valid: write enq_pd at tail and advance tail by 1.
REQ-016 SHALL drive deq_valid = (count != 0) and deq_pd = mem[head], combinationally from registered state (zero-latency offer).
REQ-017 SHALL, on a simultaneous enqueue and dequeue, perform both; count is unchanged.
REQ-018 SHALL, when an enqueue arrives while full (count == DEPTH), drop the write, leave the pointers unchanged and set overflow_err.
REQ-019 SHALL wrap pointers modulo 2*DEPTH; full = (indices equal, wrap bits differ); empty = pointers equal.
REQ-020 SHALL, on flush, set head <= tail_next with opposite wrap bit, making count = DEPTH; tail_next includes any same-cycle enqueue; dequeue that cycle is suppressed.
REQ-021 SHALL, after flush, present the physical registers not held in the retirement map, in the order they were originally freed.
REQ-022 SHALL drive count = tail - head, PHYS_BITS wide, registered.

Reset
REQ-023 SHALL on rst load mem[i] = 2**ARCH_BITS + i for i in 0..DEPTH-1, so default entries are p32..p63.
REQ-024 SHALL on rst set head = 0, tail = DEPTH (wrap bit 1), count = DEPTH, overflow_err = 0.
REQ-025 SHALL give rst priority over flush, enqueue and dequeue; reset mid-operation discards all in-flight state.

Configuration
REQ-026 SHALL, with FREE_LIST_BYPASS_EN defined: when empty and enq_valid, drive deq_valid = 1 and deq_pd = enq_pd that cycle; a handshake then consumes the value without writing mem, and the pointers advance together.
REQ-027 SHALL, without FREE_LIST_BYPASS_EN, hold deq_valid = 0 whenever count == 0, regardless of enq_valid.

Structure
REQ-028 SHALL take PHYS_BITS, ARCH_BITS, DEPTH and the phys_reg_t typedef from the shared rename package used by the RAT and retirement map.
REQ-029 SHALL be a single module with no sub-modules; the storage is a flop array.

Verification
REQ-030 SHALL cover: reset, then deq_ready high for 3 cycles -> deq_pd = 32, 33, 34; count 32 -> 29.
REQ-031 SHALL cover: 32 consecutive dequeues -> deq_valid = 0 and count = 0; enq_valid with enq_pd = 40 -> next cycle deq_valid = 1, deq_pd = 40 (with bypass: same cycle).
REQ-032 SHALL cover: from full, enq_valid with enq_pd = 5 -> overflow_err = 1 and sticky, count stays 32, mem unchanged.
REQ-033 SHALL cover: 4 dequeues (32..35), 1 enqueue of 3, then flush -> count = 32; deq_pd sequence 33, 34, 35, 36, ..., 63, 3 until wrap.
REQ-034 SHALL cover: flush coinciding with enq_valid = 1 and enq_pd = 7 -> entry 7 included; count = 32; no dequeue that cycle.
REQ-035 SHALL cover: random enq/deq over more than 100 wraps checked against a queue model; rst asserted mid-stream -> state equals REQ-023/REQ-024 next cycle.

Source files
------------

// File: rtl/free_list_pkg.sv
// Shared rename definitions used by the RAT, the retirement map and the free list.
// Physical and architectural register widths and the phys_reg_t index type.
package free_list_pkg;

    localparam int RN_PHYS_BITS = 6;
    localparam int RN_ARCH_BITS = 5;
    localparam int RN_DEPTH     = (1 << RN_PHYS_BITS) - (1 << RN_ARCH_BITS);

    typedef logic [RN_PHYS_BITS-1:0] phys_reg_t;

    function automatic phys_reg_t reset_pd(input int i);
        return phys_reg_t'((1 << RN_ARCH_BITS) + i);
    endfunction

endpackage

// File: rtl/free_list.sv
// Physical register free list: circular queue with flush recovery.
// Define FREE_LIST_BYPASS_EN to forward an enqueue straight to deq when empty.
module free_list
    import free_list_pkg::*;
#(
    parameter int PHYS_BITS = RN_PHYS_BITS,
    parameter int ARCH_BITS = RN_ARCH_BITS
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 flush,
    input  logic                 enq_valid,
    input  logic [PHYS_BITS-1:0] enq_pd,
    input  logic                 deq_ready,
    output logic                 deq_valid,
    output logic [PHYS_BITS-1:0] deq_pd,
    output logic [PHYS_BITS-1:0] count,
    output logic                 overflow_err
);

    localparam int DEPTH = (1 << PHYS_BITS) - (1 << ARCH_BITS);
    localparam int IDX_W = $clog2(DEPTH);
    localparam int PTR_W = IDX_W + 1;

    typedef logic [PTR_W-1:0] ptr_t;

    logic [PHYS_BITS-1:0] mem [DEPTH];
    ptr_t head;
    ptr_t tail;
    ptr_t head_n;
    ptr_t tail_n;

    logic full;
    logic enq_fire;
    logic deq_fire;
    logic mem_we;
    logic byp;

    assign full = (head[IDX_W-1:0] == tail[IDX_W-1:0])
               && (head[IDX_W] != tail[IDX_W]);

    always_comb begin
        byp = 1'b0;
`ifdef FREE_LIST_BYPASS_EN
        byp       = (count == '0) && enq_valid;
        deq_valid = (count != '0) || enq_valid;
        deq_pd    = byp ? enq_pd : mem[head[IDX_W-1:0]];
`else
        deq_valid = (count != '0);
        deq_pd    = mem[head[IDX_W-1:0]];
`endif
        enq_fire = enq_valid && !full;
        deq_fire = deq_valid && deq_ready && !flush;
        // A bypassed register is consumed in flight and never lands in mem.
        mem_we   = enq_fire && !(byp && deq_fire);
        tail_n   = tail + PTR_W'(enq_fire);
        if (flush)
            head_n = {~tail_n[IDX_W], tail_n[IDX_W-1:0]};
        else
            head_n = head + PTR_W'(deq_fire);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++)
                mem[i] <= PHYS_BITS'((1 << ARCH_BITS) + i);
            head         <= '0;
            tail         <= PTR_W'(DEPTH);
            count        <= PHYS_BITS'(DEPTH);
            overflow_err <= 1'b0;
        end else begin
            if (mem_we)
                mem[tail[IDX_W-1:0]] <= enq_pd;
            head  <= head_n;
            tail  <= tail_n;
            count <= PHYS_BITS'(ptr_t'(tail_n - head_n));
            if (enq_valid && full)
                overflow_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_free_list.sv
// Free list bench: directed scenarios plus randomized traffic against a
// queue model that tracks the free set and the last DEPTH freed registers.
module tb_free_list;

    localparam int DEPTH = 32;

    logic       clk;
    logic       rst;
    logic       flush;
    logic       enq_valid;
    logic [5:0] enq_pd;
    logic       deq_ready;
    logic       deq_valid;
    logic [5:0] deq_pd;
    logic [5:0] count;
    logic       overflow_err;

    int passed;
    int total;

    int  q[$];
    int  hist[$];
    bit  m_ovf;

    free_list dut (
        .clk         (clk),
        .rst         (rst),
        .flush       (flush),
        .enq_valid   (enq_valid),
        .enq_pd      (enq_pd),
        .deq_ready   (deq_ready),
        .deq_valid   (deq_valid),
        .deq_pd      (deq_pd),
        .count       (count),
        .overflow_err(overflow_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic bit m_valid();
`ifdef FREE_LIST_BYPASS_EN
        return (q.size() != 0) || enq_valid;
`else
        return q.size() != 0;
`endif
    endfunction

    function automatic logic [5:0] m_pd();
        if (q.size() != 0)
            return 6'(q[0]);
        return enq_pd;
    endfunction

    task automatic model_reset();
        q.delete();
        hist.delete();
        for (int i = 0; i < DEPTH; i++) begin
            q.push_back(32 + i);
            hist.push_back(32 + i);
        end
        m_ovf = 1'b0;
    endtask

    task automatic drive(input bit ev, input int ep, input bit dr,
                         input bit fl);
        enq_valid = ev;
        enq_pd    = 6'(ep);
        deq_ready = dr;
        flush     = fl;
    endtask

    // Advance one clock and apply the same cycle to the model.
    task automatic tick();
        bit deq;
        bit byp;
        @(posedge clk);
        if (rst) begin
            model_reset();
        end else begin
            deq = m_valid() && deq_ready && !flush;
            byp = (q.size() == 0) && enq_valid;
`ifndef FREE_LIST_BYPASS_EN
            byp = 1'b0;
`endif
            if (enq_valid && q.size() == DEPTH)
                m_ovf = 1'b1;
            if (byp && deq) begin
                // consumed in flight
            end else begin
                if (deq)
                    void'(q.pop_front());
                if (enq_valid && q.size() + (deq ? 1 : 0) < DEPTH + 0
                    && !(q.size() + (deq ? 1 : 0) == DEPTH)) begin
                    q.push_back(int'(enq_pd));
                    hist.push_back(int'(enq_pd));
                    if (hist.size() > DEPTH)
                        void'(hist.pop_front());
                end
            end
            if (flush)
                q = hist;
        end
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        drive(0, 0, 0, 0);
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        drive(0, 0, 0, 0);
        #1;
        total++;
        if (count !== 6'd32) $display("FAIL reset_count got %0d want 32", count);
        else passed++;
        total++;
        if (deq_valid !== 1'b1) $display("FAIL reset_valid got %b want 1", deq_valid);
        else passed++;
        total++;
        if (deq_pd !== 6'd32) $display("FAIL reset_pd got %0d want 32", deq_pd);
        else passed++;
        total++;
        if (overflow_err !== 1'b0) $display("FAIL reset_ovf got %b want 0", overflow_err);
        else passed++;
    endtask

    task automatic test_deq3();
        do_reset();
        for (int i = 0; i < 3; i++) begin
            drive(0, 0, 1, 0);
            #1;
            total++;
            if (deq_pd !== 6'(32 + i))
                $display("FAIL deq3_pd[%0d] got %0d want %0d", i, deq_pd, 32 + i);
            else passed++;
            total++;
            if (count !== 6'(32 - i))
                $display("FAIL deq3_count[%0d] got %0d want %0d", i, count, 32 - i);
            else passed++;
            tick();
        end
        drive(0, 0, 0, 0);
        #1;
        total++;
        if (count !== 6'd29) $display("FAIL deq3_final got %0d want 29", count);
        else passed++;
    endtask

    task automatic test_drain_refill();
        do_reset();
        for (int i = 0; i < DEPTH; i++) begin
            drive(0, 0, 1, 0);
            tick();
        end
        drive(0, 0, 1, 0);
        #1;
        total++;
        if (deq_valid !== 1'b0) $display("FAIL drain_valid got %b want 0", deq_valid);
        else passed++;
        total++;
        if (count !== 6'd0) $display("FAIL drain_count got %0d want 0", count);
        else passed++;
        drive(1, 40, 0, 0);
        #1;
`ifdef FREE_LIST_BYPASS_EN
        total++;
        if (deq_valid !== 1'b1 || deq_pd !== 6'd40)
            $display("FAIL bypass_same_cycle got %b/%0d want 1/40", deq_valid, deq_pd);
        else passed++;
`else
        total++;
        if (deq_valid !== 1'b0)
            $display("FAIL refill_same_cycle got %b want 0", deq_valid);
        else passed++;
`endif
        tick();
        drive(0, 0, 0, 0);
        #1;
        total++;
        if (deq_valid !== 1'b1 || deq_pd !== 6'd40)
            $display("FAIL refill_next got %b/%0d want 1/40", deq_valid, deq_pd);
        else passed++;
        total++;
        if (count !== 6'd1) $display("FAIL refill_count got %0d want 1", count);
        else passed++;
    endtask

    task automatic test_overflow();
        do_reset();
        drive(1, 5, 0, 0);
        tick();
        drive(0, 0, 0, 0);
        #1;
        total++;
        if (overflow_err !== 1'b1) $display("FAIL ovf_set got %b want 1", overflow_err);
        else passed++;
        total++;
        if (count !== 6'd32) $display("FAIL ovf_count got %0d want 32", count);
        else passed++;
        tick();
        tick();
        total++;
        if (overflow_err !== 1'b1) $display("FAIL ovf_sticky got %b want 1", overflow_err);
        else passed++;
        for (int i = 0; i < DEPTH; i++) begin
            drive(0, 0, 1, 0);
            #1;
            total++;
            if (deq_pd !== 6'(32 + i))
                $display("FAIL ovf_mem[%0d] got %0d want %0d", i, deq_pd, 32 + i);
            else passed++;
            tick();
        end
    endtask

    task automatic test_flush_seq();
        logic [5:0] want;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            drive(0, 0, 1, 0);
            tick();
        end
        drive(1, 3, 0, 0);
        tick();
        drive(0, 0, 0, 1);
        tick();
        drive(0, 0, 1, 0);
        #1;
        total++;
        if (count !== 6'd32) $display("FAIL flush_count got %0d want 32", count);
        else passed++;
        for (int i = 0; i < DEPTH; i++) begin
            want = (i < 31) ? 6'(33 + i) : 6'd3;
            drive(0, 0, 1, 0);
            #1;
            total++;
            if (deq_valid !== 1'b1 || deq_pd !== want)
                $display("FAIL flush_seq[%0d] got %0d want %0d", i, deq_pd, want);
            else passed++;
            tick();
        end
    endtask

    task automatic test_flush_enq();
        logic [5:0] want;
        do_reset();
        for (int i = 0; i < 2; i++) begin
            drive(0, 0, 1, 0);
            tick();
        end
        drive(1, 7, 1, 1);
        tick();
        drive(0, 0, 0, 0);
        #1;
        total++;
        if (count !== 6'd32) $display("FAIL flush_enq_count got %0d want 32", count);
        else passed++;
        for (int i = 0; i < DEPTH; i++) begin
            want = (i < 31) ? 6'(33 + i) : 6'd7;
            drive(0, 0, 1, 0);
            #1;
            total++;
            if (deq_pd !== want)
                $display("FAIL flush_enq_seq[%0d] got %0d want %0d", i, deq_pd, want);
            else passed++;
            tick();
        end
    endtask

    task automatic test_random();
        bit ev;
        bit dr;
        bit fl;
        do_reset();
        for (int c = 0; c < 8000; c++) begin
            ev = ($urandom_range(0, 9) < 6);
            dr = ($urandom_range(0, 9) < 7);
            fl = ($urandom_range(0, 99) < 2);
`ifdef FREE_LIST_BYPASS_EN
            if (q.size() == 0)
                dr = 1'b0;
`endif
            drive(ev, int'($urandom_range(0, 63)), dr, fl);
            rst = (c == 4000);
            #1;
            if (!rst) begin
                total++;
                if (deq_valid !== m_valid())
                    $display("FAIL rnd_valid c=%0d got %b want %b", c, deq_valid, m_valid());
                else passed++;
                if (m_valid()) begin
                    total++;
                    if (deq_pd !== m_pd())
                        $display("FAIL rnd_pd c=%0d got %0d want %0d", c, deq_pd, m_pd());
                    else passed++;
                end
                total++;
                if (count !== 6'(q.size()))
                    $display("FAIL rnd_count c=%0d got %0d want %0d", c, count, q.size());
                else passed++;
                total++;
                if (overflow_err !== m_ovf)
                    $display("FAIL rnd_ovf c=%0d got %b want %b", c, overflow_err, m_ovf);
                else passed++;
            end
            tick();
            if (rst) begin
                rst = 1'b0;
                drive(0, 0, 0, 0);
                #1;
                total++;
                if (count !== 6'd32 || deq_pd !== 6'd32 || deq_valid !== 1'b1
                    || overflow_err !== 1'b0)
                    $display("FAIL mid_reset got cnt=%0d pd=%0d v=%b ovf=%b want 32/32/1/0",
                             count, deq_pd, deq_valid, overflow_err);
                else passed++;
            end
        end
    endtask

    initial begin
        passed = 0;
        total  = 0;
        rst    = 1'b1;
        drive(0, 0, 0, 0);
        model_reset();
        test_reset();
        test_deq3();
        test_drain_refill();
        test_overflow();
        test_flush_seq();
        test_flush_enq();
        test_random();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
